// File: rtl/md_unit_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit: op encodings,
// default latencies and the D-stage hazard classification used by the stall controller.
`ifndef MD_UNIT_PKG_SV
`define MD_UNIT_PKG_SV

// D-stage instruction touches HI/LO or is an md op, and the unit cannot serve it yet.
`define MD_DEP_IN_D(d_md_dep, md_busy) ((d_md_dep) && (md_busy))

package md_unit_pkg;

  localparam int MD_WIDTH       = 32;
  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_RSV6  = 3'd6,
    MD_RSV7  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic md_is_multicycle(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  // Hold D while HI/LO are in flight, including an op being issued from E this cycle.
  function automatic logic md_dep_stall(input logic d_md_dep, input logic md_busy,
                                        input logic e_start, input logic [2:0] e_op);
    return d_md_dep && (md_busy || (e_start && md_is_multicycle(e_op)));
  endfunction

endpackage

`endif

// File: rtl/md_unit_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
interface md_unit_if #(parameter int WIDTH = 32);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, op, A, B, flush,
    input  busy, HI, LO
  );

  modport slave (
    input  start, op, A, B, flush,
    output busy, HI, LO
  );

endinterface

// File: rtl/md_divider.sv
// Combinational signed/unsigned divider: quotient truncates toward zero and the
// remainder takes the dividend's sign; a zero divisor yields zeros plus a flag.
module md_divider #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             div_zero_o
);

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] uquo;
  logic [WIDTH-1:0] urem;

  always_comb begin
    a_neg      = signed_i & a_i[WIDTH-1];
    b_neg      = signed_i & b_i[WIDTH-1];
    a_mag      = a_neg ? (-a_i) : a_i;
    b_mag      = b_neg ? (-b_i) : b_i;
    div_zero_o = (b_i == '0);
    uquo       = '0;
    urem       = '0;
    if (!div_zero_o) begin
      uquo = a_mag / b_mag;
      urem = a_mag % b_mag;
    end
    // Most-negative / -1 wraps back to most-negative with zero remainder.
    quo_o = (a_neg ^ b_neg) ? (-uquo) : uquo;
    rem_o = a_neg ? (-urem) : urem;
  end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit owning HI/LO. Results are computed at issue,
// held as pending, and committed when the latency counter expires.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | no op in flight; accepts md ops, mthi/mtlo write HI/LO directly
//   ST_RUN  | mult/div in flight; counter counts down, commit on 1 -> 0
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH       = MD_WIDTH,
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic    clk,
  input  logic    reset_n,
  md_unit_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;

  logic               accept;
  logic               op_signed;
  logic [2*WIDTH-1:0] mul_a;
  logic [2*WIDTH-1:0] mul_b;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_rem;
  logic               div_zero;

  assign accept    = md.start && !md.flush && (state_q == ST_IDLE);
  assign op_signed = md_is_signed(md.op);

  // Sign/zero-extend to full width so one unsigned multiply serves both flavours.
  assign mul_a   = {{WIDTH{op_signed & md.A[WIDTH-1]}}, md.A};
  assign mul_b   = {{WIDTH{op_signed & md.B[WIDTH-1]}}, md.B};
  assign product = mul_a * mul_b;

  md_divider #(.WIDTH(WIDTH)) u_div (
    .a_i        (md.A),
    .b_i        (md.B),
    .signed_i   (op_signed),
    .quo_o      (div_quo),
    .rem_o      (div_rem),
    .div_zero_o (div_zero)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (md.op)
            MD_MULT, MD_MULTU: begin
              pend_hi_d = product[2*WIDTH-1:WIDTH];
              pend_lo_d = product[WIDTH-1:0];
              pend_wr_d = 1'b1;
              cnt_d     = CNT_MULT;
              state_d   = ST_RUN;
            end
            MD_DIV, MD_DIVU: begin
              pend_hi_d = div_rem;
              pend_lo_d = div_quo;
              pend_wr_d = !div_zero;
              cnt_d     = CNT_DIV;
              state_d   = ST_RUN;
            end
            MD_MTHI: hi_d = md.A;
            MD_MTLO: lo_d = md.A;
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d   = ST_IDLE;
          pend_wr_d = 1'b0;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign md.busy = (state_q == ST_RUN);
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a cycle-level transaction model is compared every
// cycle, with literal expectations pinning the model on each directed case.
module tb_md_unit;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(32)) md_if ();

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .md      (md_if.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Model: architectural HI/LO, plus one pending result that lands at a cycle number.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          m_pend, m_wr;
  int          cyc, m_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hi   = '0;
    m_lo   = '0;
    p_hi   = '0;
    p_lo   = '0;
    m_pend = 1'b0;
    m_wr   = 1'b0;
  endtask

  task automatic model_step();
    logic [63:0] p;
    logic [63:0] q64;
    logic [63:0] r64;
    longint      sa, sb;
    bit          was_busy;
    if (!reset_n) return;
    cyc++;
    was_busy = m_pend;
    if (m_pend && cyc == m_done) begin
      if (m_wr) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
      m_pend = 1'b0;
    end
    if (md_if.start && !md_if.flush && !was_busy) begin
      sa = longint'($signed(md_if.A));
      sb = longint'($signed(md_if.B));
      case (md_if.op)
        3'd0, 3'd1: begin
          if (md_if.op == 3'd0) p = sa * sb;
          else                  p = {32'd0, md_if.A} * {32'd0, md_if.B};
          p_hi = p[63:32];
          p_lo = p[31:0];
          m_wr = 1'b1;
          m_pend = 1'b1;
          m_done = cyc + 5;
        end
        3'd2, 3'd3: begin
          m_wr = (md_if.B != 0);
          if (m_wr) begin
            if (md_if.op == 3'd2) begin
              q64 = sa / sb;
              r64 = sa % sb;
            end else begin
              q64 = {32'd0, md_if.A / md_if.B};
              r64 = {32'd0, md_if.A % md_if.B};
            end
            p_lo = q64[31:0];
            p_hi = r64[31:0];
          end
          m_pend = 1'b1;
          m_done = cyc + 10;
        end
        3'd4: m_hi = md_if.A;
        3'd5: m_lo = md_if.A;
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_if.start = 1'b1;
    md_if.op    = op;
    md_if.A     = a;
    md_if.B     = b;
    tick();
    md_if.start = 1'b0;
    md_if.A     = $urandom;
    md_if.B     = $urandom;
  endtask

  task automatic run_busy(input int exp_n, input string nm);
    int n = 0;
    while (md_if.busy && n < 100) begin
      n++;
      tick();
    end
    chk(nm, 32'(n), 32'(exp_n));
  endtask

  task automatic chk_hilo(input string nm, input logic [31:0] hi, input logic [31:0] lo);
    chk({nm, "_hi"}, md_if.HI, hi);
    chk({nm, "_lo"}, md_if.LO, lo);
    chk({nm, "_model_hi"}, m_hi, hi);
    chk({nm, "_model_lo"}, m_lo, lo);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_busy", 32'(md_if.busy), 32'(m_pend));
      chk("cyc_hi", md_if.HI, m_hi);
      chk("cyc_lo", md_if.LO, m_lo);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    md_if.start = 1'b0;
    md_if.op    = 3'd0;
    md_if.A     = '0;
    md_if.B     = '0;
    md_if.flush = 1'b0;
    cyc = 0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    chk("rst_busy", 32'(md_if.busy), 32'd0);
    chk_hilo("rst", 32'd0, 32'd0);

    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    run_busy(5, "mult_busy_len");
    chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_busy(5, "multu_busy_len");
    chk_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_busy(10, "div_busy_len");
    chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    run_busy(10, "divu_busy_len");
    chk_hilo("divu", 32'h0000_0001, 32'h7FFF_FFFC);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_busy(10, "divovf_busy_len");
    chk_hilo("divovf", 32'h0000_0000, 32'h8000_0000);

    issue(3'd4, 32'h11, 32'd0);
    chk("mthi_busy", 32'(md_if.busy), 32'd0);
    chk("mthi_hi", md_if.HI, 32'h11);
    issue(3'd5, 32'h22, 32'd0);
    chk_hilo("mtlo", 32'h11, 32'h22);

    issue(3'd2, 32'h1234, 32'd0);
    run_busy(10, "div0_busy_len");
    chk_hilo("div0", 32'h11, 32'h22);

    md_if.flush = 1'b1;
    issue(3'd0, 32'd6, 32'd7);
    md_if.flush = 1'b0;
    chk("flush_busy", 32'(md_if.busy), 32'd0);
    tick();
    chk_hilo("flush", 32'h11, 32'h22);

    issue(3'd0, 32'd6, 32'd7);
    issue(3'd4, 32'hDEAD, 32'd0);
    chk("mthi_ignored", md_if.HI, 32'h11);
    md_if.flush = 1'b1;
    tick();
    md_if.flush = 1'b0;
    run_busy(3, "mult_tail_len");
    chk_hilo("mult_commit", 32'd0, 32'd42);

    issue(3'd6, 32'h99, 32'h99);
    chk("rsv6_busy", 32'(md_if.busy), 32'd0);
    issue(3'd7, 32'h77, 32'h77);
    chk_hilo("rsv", 32'd0, 32'd42);

    issue(3'd2, 32'd100, 32'd7);
    tick();
    tick();
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst_busy", 32'(md_if.busy), 32'd0);
    chk_hilo("arst", 32'd0, 32'd0);
    tick();
    reset_n = 1'b1;
    issue(3'd5, 32'd5, 32'd0);
    chk_hilo("post_rst_mtlo", 32'd0, 32'd5);
    tick();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Execute-stage multiply/divide unit with its HI/LO registers.
- Consumes the E-stage rs/rt operands after the bypass muxes; those muxes are steered by the forwarding select lines.
- Runs mult/multu/div/divu as multi-cycle operations, does mthi/mtlo as single-cycle writes, and serves HI/LO for mfhi/mflo.
- Drives busy, which the stall controller uses to hold mfhi/mflo/md-ops in D.

Parameters:
WIDTH, 32, operand and HI/LO width
MULT_CYCLES, 5, busy cycles for mult/multu
DIV_CYCLES, 10, busy cycles for div/divu

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous reset, active-low
start  input  1  E-stage instruction is an md op or mthi/mtlo; qualified by op
op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved (no-op)
A  input  WIDTH  forwarded rs operand (E stage)
B  input  WIDTH  forwarded rt operand (E stage)
flush  input  1  E-stage instruction cancelled (exception/interrupt); kills a same-cycle start
busy  output  1  multi-cycle operation in progress
HI  output  WIDTH  architectural HI
LO  output  WIDTH  architectural LO

Behaviour:
- Reset (reset_n low, async): HI=0, LO=0, busy=0, counter=0, pending results cleared. Reset mid-operation aborts the op; HI/LO stay 0.
- Accept condition: start && !flush && !busy. When start is asserted while busy, the request is ignored. The stall controller guarantees this case does not occur; the bench still checks it.
- mthi/mtlo: on the accept edge, HI<=A (mthi) or LO<=A (mtlo). busy stays 0. Value is visible the next cycle.
- mult/multu, on the accept edge:
  - Latch the 2*WIDTH product: signed for mult, unsigned for multu. Upper half is HI, lower half is LO.
  - Load counter=MULT_CYCLES and set busy=1.
- div/divu, on the accept edge:
  - Latch quotient into the LO slot and remainder into the HI slot.
  - Signed div truncates toward zero; remainder sign follows the dividend.
  - div with A=0x80000000, B=0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Load counter=DIV_CYCLES and set busy=1.
- Divide by zero (B==0): busy runs the full DIV_CYCLES; HI/LO are left unchanged at completion.
- Counting: while busy, counter decrements each cycle. On the edge where counter goes 1->0:
  - busy<=0.
  - HI/LO<=pending values (suppressed for divide by zero).
- Timing:
  - busy is high for exactly N cycles after the accept edge.
  - The new HI/LO are visible in the cycle busy first reads 0.
  - Old HI/LO stay readable during busy.
- Operands are sampled only on the accept edge. Later changes to A/B, and flush asserted during busy, have no effect; an issued md op is not cancelled.
- State machine: IDLE -> (accept mult/div) -> RUN -> (counter==1) -> IDLE. mthi/mtlo/reserved ops stay in IDLE.
- Reserved op with start: no state change.
- HI/LO are registered outputs; there is no combinational path from A/B.

Decomposition:
- Shared package/header:
  - op encodings (MD_MULT..MD_MTLO).
  - default cycle counts.
  - the stall-classification define for "md-dependent in D" (the stall controller reuses it).
- One sub-module is natural: md_divider, a combinational signed/unsigned quotient/remainder plus the divide-by-zero flag. It keeps the sign-fix logic isolated and testable.
- Multiply is inline.

Test Plan:
- mult A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu same operands -> LO=0x7FFFFFFC, HI=1.
- HI=0x11, LO=0x22 preloaded via mthi/mtlo; div with B=0 -> busy 10 cycles; then HI=0x11, LO=0x22 unchanged.
- start+flush same cycle with mult -> busy stays 0, HI/LO unchanged. mthi during busy -> ignored; in-flight mult still commits.
- Drop reset_n at cycle 3 of a div -> HI=LO=0 and busy=0 immediately (async). After release, mtlo A=5 -> LO=5 the next cycle.
